// File: rtl/psum_sfu_if.sv
// Handshake bundle between the mac column output, the psum special-function unit and its consumer.
// The slave modport is the unit's view; the master modport is the producer/consumer side.
interface psum_sfu_if #(
    parameter int psum_bw = 16,
    parameter int cnt_bw  = 8
);
    logic                      in_valid;
    logic signed [psum_bw-1:0] in_psum;
    logic                      in_last;
    logic                      relu_en;
    logic                      in_ready;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [psum_bw-1:0] out_data;
    logic [cnt_bw-1:0]         out_cnt;
    logic                      out_ovf;

    modport slave (
        input  in_valid, in_psum, in_last, relu_en, out_ready,
        output in_ready, out_valid, out_data, out_cnt, out_ovf
    );

    modport master (
        output in_valid, in_psum, in_last, relu_en, out_ready,
        input  in_ready, out_valid, out_data, out_cnt, out_ovf
    );
endinterface

// File: rtl/psum_sfu.sv
// Partial-sum accumulator: sums a group of signed terms with wrap-around, tracks a sticky
// overflow flag and a saturating term count, and holds the (optionally ReLU'd) result until consumed.
//
// state | meaning
// IDLE  | no group open; next transfer starts a new group
// ACC   | group open; accumulating terms, gaps allowed
// HOLD  | result pending on the output; input stalled
module psum_sfu #(
    parameter int psum_bw = 16,
    parameter int cnt_bw  = 8
) (
    input  logic      clk,
    input  logic      reset,
    psum_sfu_if.slave sfu
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } sfuState_t;

    localparam logic [cnt_bw-1:0] CntMax = '1;

    sfuState_t state, stateNext;

    logic signed [psum_bw-1:0] acc, accBase, accNext, outData;
    logic [cnt_bw-1:0]         cnt, cntNext, outCnt;
    logic                      ovf, ovfTerm, ovfNext, outOvf;
    logic                      xfer;

    assign sfu.in_ready  = (state != HOLD);
    assign sfu.out_valid = (state == HOLD);
    assign sfu.out_data  = outData;
    assign sfu.out_cnt   = outCnt;
    assign sfu.out_ovf   = outOvf;

    assign xfer = sfu.in_valid && sfu.in_ready;

    // A group opening from IDLE starts from a zero sum, count and flag regardless of stale registers.
    always_comb begin
        accBase = (state == IDLE) ? '0 : acc;
        accNext = accBase + sfu.in_psum;
        ovfTerm = (accBase[psum_bw-1] == sfu.in_psum[psum_bw-1]) &&
                  (accNext[psum_bw-1] != accBase[psum_bw-1]);
        ovfNext = ((state == IDLE) ? 1'b0 : ovf) | ovfTerm;
        if (state == IDLE)
            cntNext = cnt_bw'(1);
        else if (cnt == CntMax)
            cntNext = cnt;
        else
            cntNext = cnt + cnt_bw'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, ACC: begin
                if (xfer)
                    stateNext = sfu.in_last ? HOLD : ACC;
            end
            HOLD: begin
                if (sfu.out_ready)
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            outData <= '0;
            outCnt  <= '0;
            outOvf  <= 1'b0;
        end else if (xfer) begin
            acc <= accNext;
            cnt <= cntNext;
            ovf <= ovfNext;
            if (sfu.in_last) begin
                outData <= (sfu.relu_en && accNext[psum_bw-1]) ? '0 : accNext;
                outCnt  <= cntNext;
                outOvf  <= ovfNext;
            end
        end else if (state == HOLD && sfu.out_ready) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_psum_sfu.sv
// Self-checking bench for psum_sfu: directed groups plus randomized groups checked against
// a plain-arithmetic model of group sum, saturating count, overflow and ReLU.
module tb_psum_sfu;
    localparam int PW = 16;
    localparam int CW = 8;
    localparam longint SMAX = (longint'(1) <<< (PW-1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (PW-1));
    localparam longint CSAT = (longint'(1) <<< CW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    psum_sfu_if #(.psum_bw(PW), .cnt_bw(CW)) bus ();

    psum_sfu #(.psum_bw(PW), .cnt_bw(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .sfu   (bus.slave)
    );

    int passCnt = 0;
    int totalCnt = 0;

    logic signed [PW-1:0] grp[$];

    function automatic logic [PW-1:0] mdlSum();
        longint s = 0;
        foreach (grp[i]) s += longint'(grp[i]);
        return s[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] mdlData(input logic relu);
        logic [PW-1:0] v;
        v = mdlSum();
        if (relu && v[PW-1]) return '0;
        return v;
    endfunction

    function automatic logic mdlOvf();
        longint s = 0;
        logic signed [PW-1:0] w;
        logic o = 1'b0;
        foreach (grp[i]) begin
            s = s + longint'(grp[i]);
            if (s > SMAX || s < SMIN) o = 1'b1;
            w = s[PW-1:0];
            s = longint'(w);
        end
        return o;
    endfunction

    function automatic logic [CW-1:0] mdlCnt();
        longint n;
        n = longint'(grp.size());
        if (n > CSAT) n = CSAT;
        return n[CW-1:0];
    endfunction

    // Sends grp as one group (optionally with random idle gaps), then samples the result
    // at the first falling edge after the last-term transfer.
    task automatic runGroup(input logic relu, input int gapPct,
                            output logic [PW-1:0] d, output logic [CW-1:0] c,
                            output logic o, output bit lat1);
        int n;
        int spin;
        n = grp.size();
        for (int i = 0; i < n; i++) begin
            spin = 0;
            while (gapPct > 0 && spin < 4 && int'($urandom_range(99)) < gapPct) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.in_psum  = PW'($urandom);
                bus.in_last  = 1'($urandom);
                spin++;
            end
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_psum  = grp[i];
            bus.in_last  = (i == n - 1);
            bus.relu_en  = (i == n - 1) ? relu : 1'($urandom);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        lat1 = bus.out_valid;
        spin = 0;
        while (!bus.out_valid && spin < 20) begin
            @(negedge clk);
            spin++;
        end
        d = bus.out_data;
        c = bus.out_cnt;
        o = bus.out_ovf;
    endtask

    task automatic releaseRes(output bit ok);
        bus.out_ready = 1'b1;
        @(negedge clk);
        ok = (bus.out_valid === 1'b0) && (bus.in_ready === 1'b1);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_psum = '0; bus.in_last = 1'b0;
        bus.relu_en = 1'b0;  bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        totalCnt++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", bus.in_ready); else passCnt++;
        totalCnt++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", bus.out_valid); else passCnt++;
        totalCnt++; if (bus.out_data !== '0) $display("FAIL rst_out_data got %h want 0", bus.out_data); else passCnt++;
        totalCnt++; if (bus.out_cnt !== '0) $display("FAIL rst_out_cnt got %0d want 0", bus.out_cnt); else passCnt++;
        totalCnt++; if (bus.out_ovf !== 1'b0) $display("FAIL rst_out_ovf got %b want 0", bus.out_ovf); else passCnt++;
        reset = 1'b0;
        @(negedge clk);
        totalCnt++; if (bus.in_ready !== 1'b1) $display("FAIL post_rst_in_ready got %b want 1", bus.in_ready); else passCnt++;
    endtask

    task automatic test_basic();
        logic [PW-1:0] d; logic [CW-1:0] c; logic o; bit lat1;
        grp = '{16'sd5, -16'sd2, 16'sd7};
        bus.out_ready = 1'b1;
        runGroup(1'b0, 0, d, c, o, lat1);
        totalCnt++; if (lat1 !== 1'b1) $display("FAIL basic_latency got %b want 1", lat1); else passCnt++;
        totalCnt++; if (d !== 16'd10) $display("FAIL basic_data got %h want 000a", d); else passCnt++;
        totalCnt++; if (c !== 8'd3) $display("FAIL basic_cnt got %0d want 3", c); else passCnt++;
        totalCnt++; if (o !== 1'b0) $display("FAIL basic_ovf got %b want 0", o); else passCnt++;
        @(negedge clk);
        totalCnt++; if (bus.out_valid !== 1'b0) $display("FAIL basic_consumed got %b want 0", bus.out_valid); else passCnt++;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_relu();
        logic [PW-1:0] d; logic [CW-1:0] c; logic o; bit lat1; bit ok;
        grp = '{16'sd3, -16'sd9};
        runGroup(1'b1, 0, d, c, o, lat1);
        totalCnt++; if (d !== 16'h0000) $display("FAIL relu_on_data got %h want 0000", d); else passCnt++;
        totalCnt++; if (c !== 8'd2) $display("FAIL relu_on_cnt got %0d want 2", c); else passCnt++;
        releaseRes(ok);
        totalCnt++; if (ok !== 1'b1) $display("FAIL relu_release got %b want 1", ok); else passCnt++;
        runGroup(1'b0, 0, d, c, o, lat1);
        totalCnt++; if (d !== 16'hFFFA) $display("FAIL relu_off_data got %h want fffa", d); else passCnt++;
        releaseRes(ok);
    endtask

    task automatic test_overflow();
        logic [PW-1:0] d; logic [CW-1:0] c; logic o; bit lat1; bit ok;
        grp = '{16'sh7FFF, 16'sd1};
        runGroup(1'b0, 0, d, c, o, lat1);
        totalCnt++; if (d !== 16'h8000) $display("FAIL ovf_data got %h want 8000", d); else passCnt++;
        totalCnt++; if (o !== 1'b1) $display("FAIL ovf_flag got %b want 1", o); else passCnt++;
        releaseRes(ok);
        grp = '{16'sd1};
        runGroup(1'b0, 0, d, c, o, lat1);
        totalCnt++; if (o !== 1'b0) $display("FAIL ovf_cleared got %b want 0", o); else passCnt++;
        totalCnt++; if (d !== 16'd1 || c !== 8'd1) $display("FAIL ovf_next_group got %h/%0d want 0001/1", d, c); else passCnt++;
        releaseRes(ok);
    endtask

    task automatic test_hold_stall();
        logic [PW-1:0] d; logic [CW-1:0] c; logic o; bit lat1; bit ok;
        grp = '{16'sd100, -16'sd30};
        runGroup(1'b0, 0, d, c, o, lat1);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_psum  = PW'($urandom);
            bus.in_last  = 1'($urandom);
            @(negedge clk);
            totalCnt++; if (bus.in_ready !== 1'b0) $display("FAIL hold_in_ready cyc %0d got %b want 0", k, bus.in_ready); else passCnt++;
            totalCnt++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd70 || bus.out_cnt !== 8'd2)
                $display("FAIL hold_stable cyc %0d got %b/%h/%0d want 1/0046/2", k, bus.out_valid, bus.out_data, bus.out_cnt);
            else passCnt++;
        end
        bus.in_valid = 1'b0;
        releaseRes(ok);
        totalCnt++; if (ok !== 1'b1) $display("FAIL hold_release got %b want 1", ok); else passCnt++;
        grp = '{-16'sd12, 16'sd5};
        runGroup(1'b0, 0, d, c, o, lat1);
        totalCnt++; if (d !== 16'hFFF9 || c !== 8'd2) $display("FAIL hold_next_group got %h/%0d want fff9/2", d, c); else passCnt++;
        releaseRes(ok);
    endtask

    task automatic test_reset_mid();
        logic [PW-1:0] d; logic [CW-1:0] c; logic o; bit lat1; bit ok;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_psum  = 16'sd50;
            bus.in_last  = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        totalCnt++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_cnt !== '0 || bus.out_ovf !== 1'b0)
            $display("FAIL midrst_outputs got %b/%h/%0d/%b want 0/0000/0/0", bus.out_valid, bus.out_data, bus.out_cnt, bus.out_ovf);
        else passCnt++;
        totalCnt++; if (bus.in_ready !== 1'b1) $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); else passCnt++;
        @(negedge clk);
        reset = 1'b0;
        grp = '{16'sd4};
        runGroup(1'b0, 0, d, c, o, lat1);
        totalCnt++; if (d !== 16'd4 || c !== 8'd1) $display("FAIL midrst_group got %h/%0d want 0004/1", d, c); else passCnt++;
        releaseRes(ok);
    endtask

    task automatic test_saturate();
        logic [PW-1:0] d; logic [CW-1:0] c; logic o; bit lat1; bit ok;
        grp = {};
        for (int i = 0; i < 300; i++) grp.push_back(16'sd1);
        runGroup(1'b0, 0, d, c, o, lat1);
        totalCnt++; if (c !== 8'd255) $display("FAIL sat_cnt got %0d want 255", c); else passCnt++;
        totalCnt++; if (d !== 16'd300) $display("FAIL sat_data got %0d want 300", d); else passCnt++;
        totalCnt++; if (o !== 1'b0) $display("FAIL sat_ovf got %b want 0", o); else passCnt++;
        releaseRes(ok);
    endtask

    function automatic logic signed [PW-1:0] randTerm();
        int v;
        if ($urandom_range(3) == 0)
            return ($urandom_range(1) == 0) ? PW'(16'h7FF0 + $urandom_range(15)) : PW'(16'h8000 + $urandom_range(15));
        v = int'($urandom_range(200)) - 100;
        return PW'(v);
    endfunction

    task automatic test_random();
        logic [PW-1:0] d; logic [CW-1:0] c; logic o; bit lat1; bit ok;
        logic relu;
        int n;
        for (int g = 0; g < 20; g++) begin
            n = int'($urandom_range(1, 8));
            grp = {};
            for (int i = 0; i < n; i++) grp.push_back(randTerm());
            relu = 1'($urandom);
            runGroup(relu, 30, d, c, o, lat1);
            totalCnt++; if (lat1 !== 1'b1) $display("FAIL rand_latency grp %0d got %b want 1", g, lat1); else passCnt++;
            totalCnt++; if (d !== mdlData(relu) || c !== mdlCnt() || o !== mdlOvf())
                $display("FAIL rand_result grp %0d got %h/%0d/%b want %h/%0d/%b", g, d, c, o, mdlData(relu), mdlCnt(), mdlOvf());
            else passCnt++;
            releaseRes(ok);
        end
    endtask

    // Continuous input with out_ready high: each group of N terms should occupy N+1 cycles.
    task automatic test_back_to_back();
        localparam int G = 4;
        localparam int N = 3;
        logic signed [PW-1:0] stream[$];
        logic [PW-1:0] expData[G];
        logic [CW-1:0] expCnt[G];
        logic          expOvf[G];
        int idx, k, got, lastK;
        bit drove, rdy;
        for (int g = 0; g < G; g++) begin
            grp = {};
            for (int i = 0; i < N; i++) grp.push_back(randTerm());
            expData[g] = mdlData(1'b0);
            expCnt[g]  = mdlCnt();
            expOvf[g]  = mdlOvf();
            foreach (grp[i]) stream.push_back(grp[i]);
        end
        idx = 0; k = 0; got = 0; lastK = -1; drove = 0; rdy = 0;
        bus.out_ready = 1'b1;
        bus.relu_en   = 1'b0;
        while (got < G && k < 200) begin
            @(negedge clk);
            if (drove && rdy) idx++;
            if (bus.out_valid) begin
                totalCnt++; if (bus.out_data !== expData[got] || bus.out_cnt !== expCnt[got] || bus.out_ovf !== expOvf[got])
                    $display("FAIL b2b_result grp %0d got %h/%0d/%b want %h/%0d/%b", got, bus.out_data, bus.out_cnt,
                             bus.out_ovf, expData[got], expCnt[got], expOvf[got]);
                else passCnt++;
                got++;
                lastK = k;
            end
            if (idx < G * N) begin
                bus.in_valid = 1'b1;
                bus.in_psum  = stream[idx];
                bus.in_last  = ((idx % N) == N - 1);
                drove = 1;
                rdy   = bus.in_ready;
            end else begin
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
                drove = 0;
            end
            k++;
        end
        totalCnt++; if (lastK != G * (N + 1) - 1) $display("FAIL b2b_throughput got last result cyc %0d want %0d", lastK, G * (N + 1) - 1); else passCnt++;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_overflow();
        test_hold_stall();
        test_reset_mid();
        test_saturate();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
